icache_controller: RTL and testbench

- Sequencing controller for the direct-mapped instruction-cache register array (one tag/valid per line, 2^offset_width words per block, one-cycle registered read).
- Accepts fetch requests from the core, performs lookup, and on a miss fetches the block from memory as a burst of 32-bit beats.
- Writes the block into the array and forwards the requested word to the core.
- Also sequences whole-cache invalidation for fence.i.

---
 rtl/icache_controller.sv | 130 +++++++++++++
 tb/tb_icache_controller.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/icache_controller.sv
// icache_controller: direct-mapped instruction-cache sequencer (lookup, burst refill, fence.i flush)
// reset_i is asynchronous and active low.
module icache_controller #(
  parameter int offset_width = 2,
  parameter int line_width = 6,
  localparam int tag_width = 30 - offset_width - line_width,
  localparam int block_size = 1 << offset_width
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [31:0]                req_addr_i,
  output logic                       resp_valid_o,
  input  logic                       resp_ready_i,
  output logic [31:0]                resp_instruction_o,
  input  logic                       fence_valid_i,
  output logic                       fence_ready_o,
  output logic                       fence_done_o,
  output logic                       mem_req_valid_o,
  input  logic                       mem_req_ready_i,
  output logic [31:0]                mem_req_addr_o,
  input  logic                       mem_resp_valid_i,
  output logic                       mem_resp_ready_o,
  input  logic [31:0]                mem_resp_data_i,
  output logic [31:0]                arr_address_o,
  input  logic [31:0]                arr_instruction_i,
  input  logic [tag_width-1:0]       arr_tag_i,
  input  logic                       arr_tag_valid_i,
  output logic                       arr_write_in_o,
  output logic [line_width-1:0]      arr_write_line_index_o,
  output logic [32*block_size-1:0]   arr_write_block_o,
  output logic [tag_width-1:0]       arr_write_tag_o,
  output logic                       arr_invalidate_all_o
);
  typedef enum logic [2:0] {FLUSH, IDLE, LOOKUP, MISS_REQ, REFILL, WRITE, RESP} state_t;
  state_t state_q, state_d;
  logic from_fence_q, from_fence_d;
  logic [31:2] addr_q, addr_d;
  logic [31:0] resp_q, resp_d;
  logic [offset_width-1:0] cnt_q, cnt_d;
  logic [block_size-1:0][31:0] buf_q, buf_d;
  logic [tag_width-1:0] req_tag;
  logic [line_width-1:0] req_line;
  logic [offset_width-1:0] req_word;
  assign req_tag  = addr_q[31 -: tag_width];
  assign req_line = addr_q[offset_width+2 +: line_width];
  assign req_word = addr_q[offset_width+1:2];
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q      <= FLUSH;
      from_fence_q <= 1'b0;
      addr_q       <= '0;
      resp_q       <= '0;
      cnt_q        <= '0;
      buf_q        <= '0;
    end else begin
      state_q      <= state_d;
      from_fence_q <= from_fence_d;
      addr_q       <= addr_d;
      resp_q       <= resp_d;
      cnt_q        <= cnt_d;
      buf_q        <= buf_d;
    end
  end
  always_comb begin
    state_d      = state_q;
    from_fence_d = from_fence_q;
    addr_d       = addr_q;
    resp_d       = resp_q;
    cnt_d        = cnt_q;
    buf_d        = buf_q;
    case (state_q)
      FLUSH: state_d = IDLE;
      IDLE: begin
        from_fence_d = 1'b0;
        if (fence_valid_i) begin
          from_fence_d = 1'b1;
          state_d      = FLUSH;
        end else if (req_valid_i) begin
          addr_d  = req_addr_i[31:2];
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (arr_tag_valid_i && arr_tag_i == req_tag) begin
          resp_d  = arr_instruction_i;
          state_d = RESP;
        end else begin
          state_d = MISS_REQ;
        end
      end
      MISS_REQ: begin
        if (mem_req_ready_i) begin
          cnt_d   = '0;
          state_d = REFILL;
        end
      end
      REFILL: begin
        if (mem_resp_valid_i) begin
          buf_d[cnt_q] = mem_resp_data_i;
          cnt_d        = cnt_q + offset_width'(1);
          state_d      = (cnt_q == '1) ? WRITE : REFILL;
        end
      end
      WRITE: begin
        // forward the requested word from the refill buffer instead of re-reading the array
        resp_d  = buf_q[req_word];
        state_d = RESP;
      end
      RESP: state_d = resp_ready_i ? IDLE : RESP;
      default: state_d = FLUSH;
    endcase
  end
  assign req_ready_o            = (state_q == IDLE) && !fence_valid_i;
  assign fence_ready_o          = state_q == IDLE;
  assign fence_done_o           = (state_q == IDLE) && from_fence_q;
  assign resp_valid_o           = state_q == RESP;
  assign resp_instruction_o     = resp_q;
  assign mem_req_valid_o        = state_q == MISS_REQ;
  assign mem_req_addr_o         = {addr_q[31:offset_width+2], {(offset_width+2){1'b0}}};
  assign mem_resp_ready_o       = state_q == REFILL;
  assign arr_address_o          = (state_q == IDLE) ? req_addr_i : {addr_q, 2'b00};
  assign arr_write_in_o         = state_q == WRITE;
  assign arr_write_line_index_o = req_line;
  assign arr_write_block_o      = buf_q;
  assign arr_write_tag_o        = req_tag;
  // the reset state is FLUSH, so gate the strobe until reset is released
  assign arr_invalidate_all_o   = (state_q == FLUSH) && reset_i;
endmodule

// File: tb/tb_icache_controller.sv
// tb_icache_controller: directed plus randomized fetch/fence sequence with an array model,
// a memory image and a residency reference model.
module tb_icache_controller;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic req_valid = 1'b0, req_ready;
  logic [31:0] req_addr = '0;
  logic resp_valid, resp_ready = 1'b0;
  logic [31:0] resp_instruction;
  logic fence_valid = 1'b0, fence_ready, fence_done;
  logic mem_req_valid, mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic mem_resp_valid = 1'b0, mem_resp_ready;
  logic [31:0] mem_resp_data = '0;
  logic [31:0] arr_address;
  logic [31:0] arr_instruction = '0;
  logic [21:0] arr_tag = '0;
  logic arr_tag_valid = 1'b0;
  logic arr_write_in;
  logic [5:0] arr_write_line_index;
  logic [127:0] arr_write_block;
  logic [21:0] arr_write_tag;
  logic arr_invalidate_all;
  int n_chk = 0, n_pass = 0;
  bit ref_v[64];
  bit [21:0] ref_tag[64];
  bit a_v[64];
  bit [21:0] a_tag[64];
  bit [31:0] a_dat[64][4];
  always #5 clock = ~clock;
  icache_controller dut (
    .clock_i(clock), .reset_i(reset_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_instruction_o(resp_instruction),
    .fence_valid_i(fence_valid), .fence_ready_o(fence_ready), .fence_done_o(fence_done),
    .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready), .mem_req_addr_o(mem_req_addr),
    .mem_resp_valid_i(mem_resp_valid), .mem_resp_ready_o(mem_resp_ready), .mem_resp_data_i(mem_resp_data),
    .arr_address_o(arr_address), .arr_instruction_i(arr_instruction), .arr_tag_i(arr_tag),
    .arr_tag_valid_i(arr_tag_valid), .arr_write_in_o(arr_write_in),
    .arr_write_line_index_o(arr_write_line_index), .arr_write_block_o(arr_write_block),
    .arr_write_tag_o(arr_write_tag), .arr_invalidate_all_o(arr_invalidate_all)
  );
  // register-array model with a one-cycle registered read
  always @(posedge clock) begin
    arr_tag         <= a_tag[arr_address[9:4]];
    arr_tag_valid   <= a_v[arr_address[9:4]];
    arr_instruction <= a_dat[arr_address[9:4]][arr_address[3:2]];
    if (arr_write_in) begin
      a_v[arr_write_line_index]   <= 1'b1;
      a_tag[arr_write_line_index] <= arr_write_tag;
      for (int j = 0; j < 4; j++) a_dat[arr_write_line_index][j] <= arr_write_block[32*j +: 32];
    end
    if (arr_invalidate_all) for (int i = 0; i < 64; i++) a_v[i] <= 1'b0;
  end
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a[31:4] == 28'h104) ? 32'hA0 + 32'(a[3:2]) : {a[31:2], 2'b00} * 32'h9E37_79B1;
  endfunction
  task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    assert (o === e) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", t, o, e);
  endtask
  task automatic ref_clear();
    for (int i = 0; i < 64; i++) ref_v[i] = 1'b0;
  endtask
  task automatic fetch(input logic [31:0] a, input int mw, input int gmax, input int rw);
    logic [31:0] blk;
    bit exp_hit, done, seen_m, seen_w, seen_r;
    int k, beat, gap, kl, m, r;
    blk = {a[31:4], 4'h0};
    exp_hit = ref_v[a[9:4]] && ref_tag[a[9:4]] == a[31:10];
    k = 0; beat = 0; gap = 0; kl = -100; m = mw; r = rw;
    done = 0; seen_m = 0; seen_w = 0; seen_r = 0;
    req_valid = 1'b1; req_addr = a;
    #1 chk("req_ready", 32'(req_ready), 32'd1);
    @(posedge clock); #1;
    req_valid = 1'b0; req_addr = $urandom;
    k = 1;
    while (!done && k < 400) begin
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; resp_ready = 1'b0;
      if (mem_req_valid) begin
        seen_m = 1;
        chk("mem_req_addr", mem_req_addr, blk);
        if (m > 0) m--; else mem_req_ready = 1'b1;
      end
      if (mem_resp_ready) begin
        if (gap > 0) gap--;
        else begin
          mem_resp_valid = 1'b1;
          mem_resp_data = mem_word(blk + 32'(4 * beat));
          beat++;
          gap = $urandom_range(0, gmax);
          if (beat == 4) kl = k;
        end
      end
      if (arr_write_in) begin
        seen_w = 1;
        chk("wr_cycle", k, kl + 1);
        chk("wr_index", 32'(arr_write_line_index), 32'(a[9:4]));
        chk("wr_tag", 32'(arr_write_tag), 32'(a[31:10]));
        for (int j = 0; j < 4; j++) chk("wr_block", arr_write_block[32*j +: 32], mem_word(blk + 32'(4 * j)));
        chk("wr_no_inval", 32'(arr_invalidate_all), 32'd0);
      end
      if (resp_valid) begin
        if (!seen_r) chk("resp_latency", k, exp_hit ? 2 : kl + 2);
        seen_r = 1;
        chk("resp_instr", resp_instruction, mem_word(a));
        if (r > 0) r--; else begin resp_ready = 1'b1; done = 1; end
      end
      @(posedge clock); #1;
      k++;
    end
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; resp_ready = 1'b0;
    chk("fetch_done", 32'(done), 32'd1);
    chk("miss_seen", 32'(seen_m), 32'(!exp_hit));
    chk("write_seen", 32'(seen_w), 32'(!exp_hit));
    chk("beats", beat, exp_hit ? 0 : 4);
    chk("resp_released", 32'(resp_valid), 32'd0);
    ref_v[a[9:4]] = 1'b1;
    ref_tag[a[9:4]] = a[31:10];
  endtask
  task automatic do_fence(input bit with_req);
    fence_valid = 1'b1; req_valid = with_req; req_addr = 32'h0000_1048;
    #1;
    chk("fence_ready", 32'(fence_ready), 32'd1);
    chk("fence_req_blocked", 32'(req_ready), 32'd0);
    @(posedge clock); #1;
    fence_valid = 1'b0; req_valid = 1'b0;
    chk("fence_inval", 32'(arr_invalidate_all), 32'd1);
    chk("fence_done_early", 32'(fence_done), 32'd0);
    chk("fence_busy", 32'(req_ready), 32'd0);
    @(posedge clock); #1;
    chk("fence_inval_end", 32'(arr_invalidate_all), 32'd0);
    chk("fence_done", 32'(fence_done), 32'd1);
    chk("fence_idle", 32'(req_ready), 32'd1);
    ref_clear();
    @(posedge clock); #1;
    chk("fence_done_pulse", 32'(fence_done), 32'd0);
  endtask
  initial begin
    int n;
    ref_clear();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_inval", 32'(arr_invalidate_all), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_fence_ready", 32'(fence_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mem_req", 32'(mem_req_valid), 32'd0);
    chk("rst_resp_instr", resp_instruction, 32'd0);
    reset_n = 1'b1;
    #1;
    chk("flush_inval", 32'(arr_invalidate_all), 32'd1);
    chk("flush_no_done", 32'(fence_done), 32'd0);
    chk("flush_req_ready", 32'(req_ready), 32'd0);
    @(posedge clock); #1;
    chk("flush_inval_end", 32'(arr_invalidate_all), 32'd0);
    chk("flush_no_done_idle", 32'(fence_done), 32'd0);
    chk("idle_req_ready", 32'(req_ready), 32'd1);
    fetch(32'h0000_1044, 3, 2, 4);
    fetch(32'h0000_1048, 0, 0, 0);
    do_fence(1'b1);
    fetch(32'h0000_1048, 0, 0, 0);
    req_valid = 1'b1; req_addr = 32'h0000_2000;
    @(posedge clock); #1;
    req_valid = 1'b0;
    n = 0;
    while (!mem_req_valid && n < 10) begin @(posedge clock); #1; n++; end
    chk("abort_mreq", 32'(mem_req_valid), 32'd1);
    mem_req_ready = 1'b1;
    @(posedge clock); #1;
    mem_req_ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      mem_resp_valid = 1'b1; mem_resp_data = mem_word(32'h0000_2000 + 32'(4 * b));
      @(posedge clock); #1;
    end
    mem_resp_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("abort_no_write", 32'(arr_write_in), 32'd0);
    chk("abort_resp_ready", 32'(mem_resp_ready), 32'd0);
    chk("abort_inval", 32'(arr_invalidate_all), 32'd0);
    chk("abort_resp_instr", resp_instruction, 32'd0);
    repeat (2) begin @(posedge clock); #1; chk("abort_hold_no_write", 32'(arr_write_in), 32'd0); end
    reset_n = 1'b1;
    #1 chk("abort_flush", 32'(arr_invalidate_all), 32'd1);
    @(posedge clock); #1;
    chk("abort_flush_end", 32'(arr_invalidate_all), 32'd0);
    chk("abort_no_done", 32'(fence_done), 32'd0);
    ref_clear();
    fetch(32'h0000_2000, 1, 1, 1);
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) do_fence(1'($urandom_range(0, 1)));
      else fetch((32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 4) | 32'($urandom_range(0, 15)),
                 $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
